split_sprite_ctrl: RTL and testbench
====================================

// Module: split_sprite_ctrl
// PURPOSE
//  Per-veggie sequencer that drives split_sprite. Launches a veggie and steps its trajectory once per frame,
//  using signed velocity and gravity. On a slice it latches the cut angle and drives the two halves apart.
//  When the veggie is finished it pulses veggie_gone for one cycle. It feeds x/y/split/angle/veggie_gone
//  to one top-half and one bottom-half split_sprite instance.
// PARAMETERS
//  WIDTH         256   sprite width in pixels
//  HEIGHT        256   sprite height in pixels
//  SCREEN_W      1024  visible width; centre x is clamped to [0, SCREEN_W-1]
//  SCREEN_H      768   visible height; off-screen limit is SCREEN_H + HEIGHT/2
//  GRAVITY       1     added to vy on every frame update
//  SEP_SPEED     2     pixels of half separation added on every SPLIT frame
//  SPLIT_FRAMES  60    SPLIT frames before the veggie is retired
// PORTS
//  pixel_clk_in     in   1   pixel clock; the only clock
//  rst_in           in   1   asynchronous, active-low reset
//  frame_in         in   1   one-cycle pulse, once per frame; the physics tick
//  launch_in        in   1   start a veggie; honoured only in IDLE
//  launch_x_in      in   11  starting centre x
//  launch_vx_in     in   8   signed starting x velocity, pixels per frame
//  launch_vy_in     in   8   signed starting y velocity; negative = upward
//  slice_in         in   1   blade hit; honoured only in WHOLE
//  slice_angle_in   in   10  cut angle, latched on an accepted slice
//  busy_out         out  1   high in WHOLE and SPLIT
//  split_out        out  1   high in SPLIT
//  angle_out        out  10  latched cut angle
//  top_x_out        out  11  top-half centre x
//  top_y_out        out  10  top-half centre y
//  bot_x_out        out  11  bottom-half centre x
//  bot_y_out        out  10  bottom-half centre y
//  veggie_gone_out  out  1   one-cycle pulse on retirement
//  missed_out       out  1   one-cycle pulse, together with veggie_gone_out, if the veggie fell unsliced
// BEHAVIOUR
//  Reset (rst_in=0, asynchronous): state=IDLE; every output 0; internal x, y, vx, vy, sep and fcnt = 0.
//  All outputs are registered. Effects of an input are visible on the cycle after it is sampled.
//  Internal state: cx, cy signed 12b; vx, vy signed 8b; sep 10b; fcnt 8b.
//  States: IDLE, WHOLE, SPLIT, GONE.
//  IDLE, launch_in=1:
//   - cx=launch_x_in; cy=SCREEN_H+HEIGHT/2; vx, vy latched; sep=0; fcnt=0.
//   - next state WHOLE.
//  Physics step, applied on frame_in in WHOLE and in SPLIT:
//   - cx += vx, clamped to [0, SCREEN_W-1].
//   - cy += vy, clamped to [-512, 1023].
//   - vy += GRAVITY, saturating at +127.
//  WHOLE:
//   - top and bottom outputs both equal the centre.
//   - slice_in=1: angle_out=slice_angle_in; sep=0; fcnt=0; next state SPLIT.
//   - Else, on frame_in, if vy>0 and the updated cy > SCREEN_H+HEIGHT/2: next state GONE with missed=1.
//   - slice_in and frame_in in the same cycle: the physics step is applied AND the slice is taken (slice wins over miss).
//  SPLIT:
//   - On frame_in: physics step, then sep += SEP_SPEED (saturating at 1023) and fcnt++.
//   - top_y = cy - sep and bot_y = cy + sep. Outputs clamp to [0, 1023]; negative values clamp to 0.
//   - top_x = bot_x = cx.
//   - GONE when fcnt reaches SPLIT_FRAMES-1 (the SPLIT_FRAMES-th frame) or the updated cy > SCREEN_H+HEIGHT/2.
//   - slice_in ignored; angle_out held.
//  GONE (exactly 1 cycle):
//   - veggie_gone_out=1; missed_out=missed.
//   - Then IDLE: split_out=0, busy_out=0, positions hold their last value.
//  launch_in outside IDLE is ignored, including in GONE. Inputs arriving while there is no frame_in only affect state, not position.
//  Reset asserted mid-flight aborts immediately to IDLE. No veggie_gone pulse is produced.
// TESTING
//  1. Reset low, then high -> all outputs 0, busy_out=0.
//     launch_in with x=512, vx=3, vy=-20 -> next cycle busy_out=1, top_x_out=512, top_y_out=896.
//  2. After T1, one frame_in -> top_x_out=515, top_y_out=876, vy=-19.
//     Slice_in with angle 90 between frames -> split_out=1, angle_out=90, top_y_out=bot_y_out.
//  3. In SPLIT with cy=400 after the step, frame_in -> top_y_out=398, bot_y_out=402.
//     Exactly 60 frames after the slice -> veggie_gone_out high for 1 cycle, missed_out=0, then split_out=0.
//  4. Launch with no slice, vy=-5 -> veggie rises, then falls.
//     Frame where cy > 896 -> veggie_gone_out=missed_out=1 for 1 cycle, then IDLE.
//  5. slice_in and frame_in in the same cycle in WHOLE -> position stepped and state SPLIT.
//     launch_in during SPLIT -> ignored (x unchanged).
//  6. Drive rst_in low mid-SPLIT, asynchronously and between clock edges -> outputs 0 immediately;
//     no veggie_gone pulse after release.

Source files
------------

// File: rtl/split_sprite_ctrl_if.sv
// Control/status bundle between a split_sprite_ctrl and the logic that launches, slices and
// renders one veggie.
interface split_sprite_ctrl_if;
  logic        frame_in;
  logic        launch_in;
  logic [10:0] launch_x_in;
  logic [7:0]  launch_vx_in;
  logic [7:0]  launch_vy_in;
  logic        slice_in;
  logic [9:0]  slice_angle_in;
  logic        busy_out;
  logic        split_out;
  logic [9:0]  angle_out;
  logic [10:0] top_x_out;
  logic [9:0]  top_y_out;
  logic [10:0] bot_x_out;
  logic [9:0]  bot_y_out;
  logic        veggie_gone_out;
  logic        missed_out;

  // Driver of the stimulus side (game logic / testbench)
  modport master (
    output frame_in, launch_in, launch_x_in, launch_vx_in, launch_vy_in,
           slice_in, slice_angle_in,
    input  busy_out, split_out, angle_out, top_x_out, top_y_out,
           bot_x_out, bot_y_out, veggie_gone_out, missed_out
  );

  // The sequencer itself
  modport slave (
    input  frame_in, launch_in, launch_x_in, launch_vx_in, launch_vy_in,
           slice_in, slice_angle_in,
    output busy_out, split_out, angle_out, top_x_out, top_y_out,
           bot_x_out, bot_y_out, veggie_gone_out, missed_out
  );
endinterface

// File: rtl/split_sprite_ctrl.sv
// Per-veggie sequencer: launches a veggie, steps its ballistic trajectory once per frame,
// separates the two halves after a slice and signals retirement with a one-cycle pulse.
module split_sprite_ctrl #(
  parameter int WIDTH        = 256,
  parameter int HEIGHT       = 256,
  parameter int SCREEN_W     = 1024,
  parameter int SCREEN_H     = 768,
  parameter int GRAVITY      = 1,
  parameter int SEP_SPEED    = 2,
  parameter int SPLIT_FRAMES = 60
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  split_sprite_ctrl_if.slave  bus
);

  if (WIDTH < 1 || HEIGHT < 2 || SPLIT_FRAMES < 1 || SPLIT_FRAMES > 256) begin : g_bad_params
    $error("split_sprite_ctrl: unsupported sprite geometry or SPLIT_FRAMES");
  end

  typedef enum logic [1:0] {IDLE, WHOLE, SPLIT, GONE} state_t;

  localparam int                 START_Y_I = SCREEN_H + HEIGHT / 2;
  localparam logic signed [11:0] START_Y   = 12'(START_Y_I);
  localparam logic signed [12:0] X_MAX     = 13'(SCREEN_W - 1);
  localparam logic signed [12:0] Y_MIN     = -13'sd512;
  localparam logic signed [12:0] Y_MAX     = 13'sd1023;
  localparam logic [7:0]         LAST_FRM  = 8'(SPLIT_FRAMES - 1);

  state_t             state_reg, state_next;
  logic signed [11:0] cx_reg, cx_next, cy_reg, cy_next;
  logic signed [7:0]  vx_reg, vx_next, vy_reg, vy_next;
  logic [9:0]         sep_reg, sep_next;
  logic [7:0]         fcnt_reg, fcnt_next;
  logic               missed_reg, missed_next;

  logic               busy_reg, busy_next;
  logic               split_reg, split_next;
  logic [9:0]         angle_reg, angle_next;
  logic [10:0]        top_x_reg, top_x_next, bot_x_reg, bot_x_next;
  logic [9:0]         top_y_reg, top_y_next, bot_y_reg, bot_y_next;
  logic               gone_reg, gone_next;
  logic               missed_out_reg, missed_out_next;

  logic signed [12:0] cx_sum, cy_sum;
  logic signed [11:0] cx_step, cy_step;
  logic signed [8:0]  vy_sum;
  logic signed [7:0]  vy_step;
  logic [10:0]        sep_sum;
  logic [9:0]         sep_step;
  logic               past_floor;
  logic signed [12:0] cy_wide, sep_wide;

  function automatic logic [9:0] clamp_y(input logic signed [12:0] v);
    if (v < 13'sd0)
      return 10'd0;
    else if (v > 13'sd1023)
      return 10'd1023;
    else
      return v[9:0];
  endfunction

  // One frame of ballistic motion, computed unconditionally and used only on frame_in
  always_comb begin
    cx_sum = $signed({cx_reg[11], cx_reg}) + $signed({{5{vx_reg[7]}}, vx_reg});
    cy_sum = $signed({cy_reg[11], cy_reg}) + $signed({{5{vy_reg[7]}}, vy_reg});
    vy_sum = $signed({vy_reg[7], vy_reg}) + $signed(9'(GRAVITY));

    if (cx_sum < 13'sd0)
      cx_step = 12'sd0;
    else if (cx_sum > X_MAX)
      cx_step = X_MAX[11:0];
    else
      cx_step = cx_sum[11:0];

    if (cy_sum < Y_MIN)
      cy_step = Y_MIN[11:0];
    else if (cy_sum > Y_MAX)
      cy_step = Y_MAX[11:0];
    else
      cy_step = cy_sum[11:0];

    vy_step    = (vy_sum > 9'sd127) ? 8'sd127 : vy_sum[7:0];
    past_floor = (cy_step > START_Y);

    sep_sum  = {1'b0, sep_reg} + 11'(SEP_SPEED);
    sep_step = (sep_sum > 11'd1023) ? 10'd1023 : sep_sum[9:0];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_next  = state_reg;
    cx_next     = cx_reg;
    cy_next     = cy_reg;
    vx_next     = vx_reg;
    vy_next     = vy_reg;
    sep_next    = sep_reg;
    fcnt_next   = fcnt_reg;
    missed_next = missed_reg;
    angle_next  = angle_reg;
    top_x_next  = top_x_reg;
    bot_x_next  = bot_x_reg;
    top_y_next  = top_y_reg;
    bot_y_next  = bot_y_reg;
    cy_wide     = '0;
    sep_wide    = '0;

    case (state_reg)
      IDLE: begin
        if (bus.launch_in) begin
          cx_next     = {1'b0, bus.launch_x_in};
          cy_next     = START_Y;
          vx_next     = bus.launch_vx_in;
          vy_next     = bus.launch_vy_in;
          sep_next    = '0;
          fcnt_next   = '0;
          missed_next = 1'b0;
          state_next  = WHOLE;
        end
      end
      WHOLE: begin
        if (bus.frame_in) begin
          cx_next = cx_step;
          cy_next = cy_step;
          vy_next = vy_step;
        end
        // A slice in the same cycle as a fatal frame still counts as a hit
        if (bus.slice_in) begin
          angle_next = bus.slice_angle_in;
          sep_next   = '0;
          fcnt_next  = '0;
          state_next = SPLIT;
        end else if (bus.frame_in && vy_reg > 8'sd0 && past_floor) begin
          missed_next = 1'b1;
          state_next  = GONE;
        end
      end
      SPLIT: begin
        if (bus.frame_in) begin
          cx_next   = cx_step;
          cy_next   = cy_step;
          vy_next   = vy_step;
          sep_next  = sep_step;
          fcnt_next = fcnt_reg + 8'd1;
          if (fcnt_reg == LAST_FRM || past_floor) begin
            missed_next = 1'b0;
            state_next  = GONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Positions track the centre while whole, spread apart while split, and hold otherwise
    cy_wide  = {cy_next[11], cy_next};
    sep_wide = {3'b000, sep_next};
    if ((state_reg == IDLE && bus.launch_in) || state_reg == WHOLE) begin
      top_x_next = cx_next[10:0];
      bot_x_next = cx_next[10:0];
      top_y_next = clamp_y(cy_wide);
      bot_y_next = clamp_y(cy_wide);
    end else if (state_reg == SPLIT) begin
      top_x_next = cx_next[10:0];
      bot_x_next = cx_next[10:0];
      top_y_next = clamp_y(cy_wide - sep_wide);
      bot_y_next = clamp_y(cy_wide + sep_wide);
    end

    busy_next       = (state_next == WHOLE) || (state_next == SPLIT);
    split_next      = (state_next == SPLIT);
    gone_next       = (state_next == GONE);
    missed_out_next = (state_next == GONE) && missed_next;
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg      <= IDLE;
      cx_reg         <= '0;
      cy_reg         <= '0;
      vx_reg         <= '0;
      vy_reg         <= '0;
      sep_reg        <= '0;
      fcnt_reg       <= '0;
      missed_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      split_reg      <= 1'b0;
      angle_reg      <= '0;
      top_x_reg      <= '0;
      bot_x_reg      <= '0;
      top_y_reg      <= '0;
      bot_y_reg      <= '0;
      gone_reg       <= 1'b0;
      missed_out_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cx_reg         <= cx_next;
      cy_reg         <= cy_next;
      vx_reg         <= vx_next;
      vy_reg         <= vy_next;
      sep_reg        <= sep_next;
      fcnt_reg       <= fcnt_next;
      missed_reg     <= missed_next;
      busy_reg       <= busy_next;
      split_reg      <= split_next;
      angle_reg      <= angle_next;
      top_x_reg      <= top_x_next;
      bot_x_reg      <= bot_x_next;
      top_y_reg      <= top_y_next;
      bot_y_reg      <= bot_y_next;
      gone_reg       <= gone_next;
      missed_out_reg <= missed_out_next;
    end
  end

  assign bus.busy_out        = busy_reg;
  assign bus.split_out       = split_reg;
  assign bus.angle_out       = angle_reg;
  assign bus.top_x_out       = top_x_reg;
  assign bus.top_y_out       = top_y_reg;
  assign bus.bot_x_out       = bot_x_reg;
  assign bus.bot_y_out       = bot_y_reg;
  assign bus.veggie_gone_out = gone_reg;
  assign bus.missed_out      = missed_out_reg;

endmodule

// File: tb/tb_split_sprite_ctrl.sv
// Self-checking bench for split_sprite_ctrl: directed scenarios followed by random play,
// every cycle compared against a frame-level behavioural model of the veggie.
module tb_split_sprite_ctrl;

  logic pixel_clk_in = 1'b0;
  logic rst_in       = 1'b0;
  always #5 pixel_clk_in = ~pixel_clk_in;

  split_sprite_ctrl_if bus ();

  split_sprite_ctrl dut (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .bus          (bus)
  );

  localparam int PH_IDLE = 0, PH_WHOLE = 1, PH_SPLIT = 2, PH_GONE = 3;
  localparam int FLOOR_Y = 896;

  int    n_checks = 0;
  int    n_errors = 0;
  string t_name   = "reset";

  // Behavioural model of the veggie
  int m_phase, m_cx, m_cy, m_vx, m_vy, m_sep, m_fcnt, m_missed, m_angle;
  int e_top_x, e_top_y, e_bot_y, e_gone, e_missed;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s.%s: got %0d, expected %0d", t_name, tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_cx = 0; m_cy = 0; m_vx = 0; m_vy = 0;
    m_sep = 0; m_fcnt = 0; m_missed = 0; m_angle = 0;
    e_top_x = 0; e_top_y = 0; e_bot_y = 0; e_gone = 0; e_missed = 0;
  endtask

  task automatic physics();
    m_cx = clampi(m_cx + m_vx, 0, 1023);
    m_cy = clampi(m_cy + m_vy, -512, 1023);
    m_vy = (m_vy + 1 > 127) ? 127 : m_vy + 1;
  endtask

  task automatic show_centre();
    e_top_x = m_cx;
    e_top_y = clampi(m_cy, 0, 1023);
    e_bot_y = e_top_y;
  endtask

  // Advance the model by one clock using the inputs currently on the bus
  task automatic model_step();
    int vy_before, f_before;
    case (m_phase)
      PH_IDLE: if (bus.launch_in) begin
        m_cx = int'(bus.launch_x_in);
        m_cy = FLOOR_Y;
        m_vx = int'($signed(bus.launch_vx_in));
        m_vy = int'($signed(bus.launch_vy_in));
        m_sep = 0; m_fcnt = 0; m_missed = 0;
        m_phase = PH_WHOLE;
        show_centre();
        $display("launch x=%0d vx=%0d vy=%0d", m_cx, m_vx, m_vy);
      end
      PH_WHOLE: begin
        vy_before = m_vy;
        if (bus.frame_in) physics();
        if (bus.slice_in) begin
          m_angle = int'(bus.slice_angle_in);
          m_sep = 0; m_fcnt = 0;
          m_phase = PH_SPLIT;
          $display("slice angle=%0d at x=%0d y=%0d", m_angle, m_cx, m_cy);
        end else if (bus.frame_in && vy_before > 0 && m_cy > FLOOR_Y) begin
          m_missed = 1;
          m_phase = PH_GONE;
        end
        show_centre();
      end
      PH_SPLIT: begin
        if (bus.frame_in) begin
          f_before = m_fcnt;
          physics();
          m_sep = (m_sep + 2 > 1023) ? 1023 : m_sep + 2;
          m_fcnt++;
          if (f_before == 59 || m_cy > FLOOR_Y) begin
            m_missed = 0;
            m_phase = PH_GONE;
          end
        end
        e_top_x = m_cx;
        e_top_y = clampi(m_cy - m_sep, 0, 1023);
        e_bot_y = clampi(m_cy + m_sep, 0, 1023);
      end
      default: m_phase = PH_IDLE;
    endcase
    e_gone   = (m_phase == PH_GONE) ? 1 : 0;
    e_missed = (e_gone == 1 && m_missed == 1) ? 1 : 0;
    if (e_gone == 1) $display("veggie gone missed=%0d", e_missed);
  endtask

  task automatic check_outputs();
    check("busy",   int'(bus.busy_out),  (m_phase == PH_WHOLE || m_phase == PH_SPLIT) ? 1 : 0);
    check("split",  int'(bus.split_out), (m_phase == PH_SPLIT) ? 1 : 0);
    check("angle",  int'(bus.angle_out), m_angle);
    check("top_x",  int'(bus.top_x_out), e_top_x);
    check("bot_x",  int'(bus.bot_x_out), e_top_x);
    check("top_y",  int'(bus.top_y_out), e_top_y);
    check("bot_y",  int'(bus.bot_y_out), e_bot_y);
    check("gone",   int'(bus.veggie_gone_out), e_gone);
    check("missed", int'(bus.missed_out), e_missed);
  endtask

  task automatic clear_inputs();
    bus.frame_in = 1'b0; bus.launch_in = 1'b0; bus.slice_in = 1'b0;
  endtask

  // One clock: inputs already on the bus are sampled, model follows, outputs checked after the edge
  task automatic cycle();
    @(posedge pixel_clk_in);
    model_step();
    #1;
    check_outputs();
    clear_inputs();
  endtask

  task automatic launch(input int x, input int vx, input int vy);
    bus.launch_in    = 1'b1;
    bus.launch_x_in  = 11'(x);
    bus.launch_vx_in = 8'(vx);
    bus.launch_vy_in = 8'(vy);
    cycle();
  endtask

  // A frame pulse followed by two quiet cycles
  task automatic frame();
    bus.frame_in = 1'b1;
    cycle();
    cycle();
    cycle();
  endtask

  // Send frames until the DUT retires the veggie; returns frames sent and whether it was missed
  task automatic frames_until_gone(input int limit, output int frames, output int missed);
    bit seen;
    seen = 0; frames = 0; missed = 0;
    while (!seen && frames < limit) begin
      bus.frame_in = 1'b1;
      cycle();
      frames++;
      if (bus.veggie_gone_out) begin
        seen = 1;
        missed = int'(bus.missed_out);
      end
      cycle();
    end
    check("gone_within_bound", int'(seen), 1);
    cycle();
  endtask

  initial begin
    int frames, missed;
    clear_inputs();
    bus.launch_x_in = '0; bus.launch_vx_in = '0; bus.launch_vy_in = '0;
    bus.slice_angle_in = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge pixel_clk_in);
    #1;
    check_outputs();
    rst_in = 1'b1;
    cycle();

    // Launch and first frame
    t_name = "launch";
    launch(512, 3, -20);
    check("t1_top_x", int'(bus.top_x_out), 512);
    check("t1_top_y", int'(bus.top_y_out), 896);
    cycle();
    t_name = "first_frame";
    frame();
    check("t2_top_x", int'(bus.top_x_out), 515);
    check("t2_top_y", int'(bus.top_y_out), 876);

    // Slice between frames, then let it fall back below the screen
    t_name = "slice";
    bus.slice_in = 1'b1; bus.slice_angle_in = 10'd90;
    cycle();
    check("t2_angle", int'(bus.angle_out), 90);
    check("t2_bot_y", int'(bus.bot_y_out), 876);
    frames_until_gone(200, frames, missed);
    check("t2_missed", missed, 0);

    // Full 60-frame split lifetime; high launch drives top half into the clamp at 0
    t_name = "split_life";
    launch(200, -4, -60);
    frame(); frame();
    bus.slice_in = 1'b1; bus.slice_angle_in = 10'd777;
    cycle();
    frames_until_gone(100, frames, missed);
    check("t3_frames", frames, 60);
    check("t3_missed", missed, 0);
    check("t3_split_after", int'(bus.split_out), 0);

    // Unsliced veggie: rises, falls, missed on the 12th frame
    t_name = "miss";
    launch(300, -2, -5);
    frames_until_gone(100, frames, missed);
    check("t4_frames", frames, 12);
    check("t4_missed", missed, 1);
    check("t4_busy_after", int'(bus.busy_out), 0);

    // Slice and frame together, then a launch attempt while split
    t_name = "slice_with_frame";
    launch(700, 5, -30);
    frame();
    bus.slice_in = 1'b1; bus.frame_in = 1'b1; bus.slice_angle_in = 10'd45;
    cycle();
    check("t5_top_x", int'(bus.top_x_out), 710);
    check("t5_split", int'(bus.split_out), 1);
    launch(100, 0, -10);
    check("t5_x_held", int'(bus.top_x_out), 710);
    frame();

    // Asynchronous abort mid-split, between clock edges
    t_name = "async_reset";
    #3;
    rst_in = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge pixel_clk_in);
    @(posedge pixel_clk_in);
    #3;
    rst_in = 1'b1;
    repeat (10) cycle();

    // Random play
    t_name = "random";
    for (int i = 0; i < 4000; i++) begin
      bus.frame_in       = ($urandom_range(0, 2) == 0);
      bus.launch_in      = ($urandom_range(0, 19) == 0);
      bus.slice_in       = ($urandom_range(0, 39) == 0);
      bus.launch_x_in    = 11'($urandom_range(0, 1023));
      bus.launch_vx_in   = 8'($urandom_range(0, 255));
      bus.launch_vy_in   = 8'(-int'($urandom_range(5, 90)));
      bus.slice_angle_in = 10'($urandom_range(0, 1023));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
